neuron_array_controller: RTL and testbench
==========================================

// Module: neuron_array_controller
// PURPOSE
//  Parametrised successor of the single-neuron controller: time-multiplexes integrate/leak/fire over N_COUNT neurons,
//  LANES per cycle. Buffers axon packets from the scheduler in a FIFO, fetches each axon's fan-out row from synapse
//  SRAM, integrates weights, then on tick applies leak, threshold and a selectable reset mode. Emits an N_COUNT spike vector.
// PARAMETERS
//  N_COUNT      256  neurons per core; must be a multiple of LANES
//  LANES        4    neurons processed per cycle in INTEG/FIRE
//  V_PRECISION  8    signed width of potential, weight, leak, vthresh
//  AXON_W       8    axon index width (= packet width = SRAM address width)
//  FIFO_DEPTH   8    packet FIFO entries; power of two, >= 2
//  RESET_MODE   0    0: v<=0 on fire; 1: v<=v-vthresh (saturating)
// PORTS
//  clk           in   1                clock
//  reset         in   1                asynchronous, active-low
//  pkt_valid     in   1                scheduler packet strobe
//  pkt_axon      in   AXON_W           axon index of packet
//  dropped_packet out 1                1-cycle pulse: packet lost, FIFO full
//  tick          in   1                end-of-timestep strobe
//  tick_overrun  out  1                1-cycle pulse: tick arrived while one pending
//  sram_req      out  1                synapse row read request (level until resp)
//  sram_addr     out  AXON_W           row address, stable while sram_req
//  sram_resp     in   1                row valid, variable latency >= 1
//  sram_rd       in   N_COUNT          connection bits, bit n -> neuron n
//  cfg_we        in   1                write neuron config
//  cfg_idx       in   $clog2(N_COUNT)  neuron index
//  cfg_data      in   neuron_cfg_t     {weight, leak, vthresh}
//  spikes        out  N_COUNT          spike vector, held until next fire
//  spikes_valid  out  1                1-cycle pulse after last FIRE group
//  busy          out  1                FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; potentials, configs, tick_pending 0; FSM IDLE. sram_resp outside WAIT ignored.
//  FIFO: push when pkt_valid & (!full | pop same cycle); pkt_valid & full & !pop -> drop + dropped_packet next cycle.
//  FSM IDLE: FIFO non-empty -> pop, REQ. Else tick_pending -> FIRE, group=0. Packets have priority over pending tick.
//  REQ: sram_req=1, sram_addr=popped axon, go WAIT. WAIT: hold req/addr; on sram_resp capture row, req=0, -> INTEG.
//  INTEG: per cycle, neurons [g*LANES +: LANES]: if conn bit, v=sat(v+weight). N_COUNT/LANES cycles -> IDLE.
//  FIRE: per group v'=sat(v-leak); if v'>=vthresh (signed): spike=1, v per RESET_MODE; else spike=0, v=v'.
//   Last group: spikes_valid pulses, spikes updated atomically, tick_pending clears -> IDLE.
//  Saturation: clamp to [-2^(V-1), 2^(V-1)-1]; never wraps.
//  tick: sets tick_pending; tick while pending (or during FIRE) -> tick_overrun pulse, merged into one fire.
//   Packets arriving during FIRE are queued for the next timestep.
//  cfg_we: applied same edge; config write to neuron in active group takes effect next use, never mid-cycle.
//  Latency: packet in empty FIFO, sram latency L -> integration done 3+L+N_COUNT/LANES cycles later.
//  Reset mid-operation clears everything incl. in-flight SRAM request; late sram_resp ignored.
// STRUCTURE
//  neuron_pkg: neuron_cfg_t packed {weight, leak, vthresh}, ctrl_state_e {IDLE,REQ,WAIT,INTEG,FIRE}, sat_add function.
//  Sub-module: pkt_fifo (parametrised DEPTH/WIDTH, push/pop/full/empty, simultaneous push+pop at full allowed).
//  Potentials and configs as register arrays; LANES-wide datapath generate loop.
// TESTING
//  1 Defaults N=256,L=4; cfg n3 {w=2,leak=1,vth=3}; pkt axon 5, row bit3 set, 2 pkts, tick -> spikes[3]=1, v3=0.
//  2 FIFO_DEPTH=8, SRAM stalled; 10 back-to-back pkts -> 8 queued, 2 dropped_packet pulses, all 8 integrated later.
//  3 weight=127, 3 pkts hit n0 -> v0 saturates 127, no wrap; leak=-? w=-128 x2 -> v clamps -128.
//  4 RESET_MODE=1, vth=3, v=7 -> fire, v=4; next tick leak=0 -> fire, v=1; next -> no spike.
//  5 tick while FIFO holds 3 pkts -> all 3 integrated before FIRE; second tick in FIRE -> tick_overrun, one fire.
//  6 reset low during WAIT -> sram_req=0 async, busy=0; later sram_resp ignored, potentials all 0.

Source files
------------

// File: rtl/neuron_array_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package   : neuron_array_controller_pkg
// Contents  : Shared neuron config type, controller states, saturating adder
// Revision  : 1.0  initial release
// ============================================================================
package neuron_array_controller_pkg;

  // Signed width of potential, weight, leak and threshold
  localparam int C_V_W = 8;

  typedef struct packed {
    logic signed [C_V_W-1:0] weight;
    logic signed [C_V_W-1:0] leak;
    logic signed [C_V_W-1:0] vthresh;
  } neuron_cfg_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    INTEG = 3'd3,
    FIRE  = 3'd4
  } ctrl_state_e;

  // a + b (or a - b when sub) computed one bit wider, clamped to the
  // signed range so the result never wraps.
  function automatic logic signed [C_V_W-1:0] sat_add(
    input logic signed [C_V_W-1:0] a,
    input logic signed [C_V_W-1:0] b,
    input logic                    sub
  );
    logic [C_V_W:0] s;
    s = sub ? ({a[C_V_W-1], a} - {b[C_V_W-1], b})
            : ({a[C_V_W-1], a} + {b[C_V_W-1], b});
    if (s[C_V_W] != s[C_V_W-1]) begin
      return s[C_V_W] ? {1'b1, {(C_V_W-1){1'b0}}} : {1'b0, {(C_V_W-1){1'b1}}};
    end
    return s[C_V_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_array_controller_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module    : neuron_array_controller_pkt_fifo
// Purpose   : Axon packet FIFO; push and pop in the same cycle at full is
//             allowed (caller gates push/pop against full/empty)
// Revision  : 1.0  initial release
// ============================================================================
module neuron_array_controller_pkt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when indices match
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
  end

  // Pointer update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_array_controller.sv
`default_nettype none
// ============================================================================
// Module    : neuron_array_controller
// Purpose   : Time-multiplexed integrate/leak/fire over N_COUNT neurons,
//             LANES per cycle, fed by buffered axon packets and synapse SRAM
// Revision  : 1.0  initial release
// ============================================================================
module neuron_array_controller
  import neuron_array_controller_pkg::*;
#(
  parameter int N_COUNT     = 256,
  parameter int LANES       = 4,
  parameter int V_PRECISION = C_V_W,  // must equal C_V_W (config struct width)
  parameter int AXON_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int RESET_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pkt_valid,
  input  logic [AXON_W-1:0]          pkt_axon,
  output logic                       dropped_packet,
  input  logic                       tick,
  output logic                       tick_overrun,
  output logic                       sram_req,
  output logic [AXON_W-1:0]          sram_addr,
  input  logic                       sram_resp,
  input  logic [N_COUNT-1:0]         sram_rd,
  input  logic                       cfg_we,
  input  logic [$clog2(N_COUNT)-1:0] cfg_idx,
  input  neuron_cfg_t                cfg_data,
  output logic [N_COUNT-1:0]         spikes,
  output logic                       spikes_valid,
  output logic                       busy
);

  localparam int c_groups = N_COUNT / LANES;
  localparam int c_gw     = (c_groups > 1) ? $clog2(c_groups) : 1;
  localparam int c_iw     = $clog2(N_COUNT);

  ctrl_state_e                   r_state, w_state_next;
  logic [c_gw-1:0]               r_group;
  logic [AXON_W-1:0]             r_addr;
  logic [N_COUNT-1:0]            r_row, r_spike_acc, w_spike_acc_next, r_spikes;
  logic                          r_spikes_valid, r_tick_pending, r_tick_overrun, r_dropped;
  logic signed [V_PRECISION-1:0] r_v   [N_COUNT];
  neuron_cfg_t                   r_cfg [N_COUNT];
  logic                          w_fifo_full, w_fifo_empty, w_push, w_pop;
  logic [AXON_W-1:0]             w_head;
  logic                          w_last_group, w_fire_done, w_active;
  logic [LANES*c_iw-1:0]         w_idx_flat;
  logic [LANES*V_PRECISION-1:0]  w_v_new_flat;
  logic [LANES-1:0]              w_lane_spike;

  // A packet is accepted when there is room, including room freed by a pop this cycle
  assign w_push       = pkt_valid && (!w_fifo_full || w_pop);
  assign w_last_group = (r_group == c_gw'(c_groups - 1));
  assign w_active     = (r_state == INTEG) || (r_state == FIRE);
  assign w_fire_done  = (r_state == FIRE) && w_last_group;

  neuron_array_controller_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXON_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (pkt_axon),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: pending packets are served before a pending tick
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty)      w_state_next = REQ;
               else if (r_tick_pending) w_state_next = FIRE;
      REQ:     w_state_next = WAIT;
      WAIT:    if (sram_resp)    w_state_next = INTEG;
      INTEG:   if (w_last_group) w_state_next = IDLE;
      FIRE:    if (w_last_group) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State-decoded outputs; sram_req follows state so async reset drops it at once
  always_comb begin
    sram_req = 1'b0;
    w_pop    = 1'b0;
    case (r_state)
      IDLE:      w_pop    = !w_fifo_empty;
      REQ, WAIT: sram_req = 1'b1;
      default:   ;
    endcase
  end

  // Group sweep counter, running only while integrating or firing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       r_group <= '0;
    else if (w_active && !w_last_group) r_group <= r_group + c_gw'(1);
    else                              r_group <= '0;
  end

  // Popped axon becomes the row address; captured row is used during INTEG
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_row  <= '0;
    end else begin
      if (w_pop)                          r_addr <= w_head;
      if ((r_state == WAIT) && sram_resp) r_row  <= sram_rd;
    end
  end

  // LANES-wide datapath: one neuron per lane in the current group
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [c_iw-1:0]               w_idx;
    neuron_cfg_t                   w_cfg;
    logic signed [V_PRECISION-1:0] w_v_cur, w_v_leaked, w_v_next;
    logic                          w_fire;

    assign w_idx      = c_iw'(r_group) * c_iw'(LANES) + c_iw'(l);
    assign w_v_cur    = r_v[w_idx];
    assign w_cfg      = r_cfg[w_idx];
    assign w_v_leaked = sat_add(w_v_cur, w_cfg.leak, 1'b1);
    assign w_fire     = (r_state == FIRE) && ($signed(w_v_leaked) >= $signed(w_cfg.vthresh));

    // Lane potential update: weight add on INTEG, leak/threshold/reset on FIRE
    always_comb begin
      w_v_next = w_v_leaked;
      if (r_state == INTEG) begin
        w_v_next = r_row[w_idx] ? sat_add(w_v_cur, w_cfg.weight, 1'b0) : w_v_cur;
      end else if (w_fire) begin
        w_v_next = (RESET_MODE == 1) ? sat_add(w_v_leaked, w_cfg.vthresh, 1'b1) : '0;
      end
    end

    assign w_idx_flat[l*c_iw +: c_iw]                 = w_idx;
    assign w_v_new_flat[l*V_PRECISION +: V_PRECISION] = w_v_next;
    assign w_lane_spike[l]                            = w_fire;
  end

  // Potential array: lanes write back their neurons every INTEG/FIRE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < N_COUNT; n++) r_v[n] <= '0;
    end else if (w_active) begin
      for (int l = 0; l < LANES; l++)
        r_v[w_idx_flat[l*c_iw +: c_iw]] <= w_v_new_flat[l*V_PRECISION +: V_PRECISION];
    end
  end

  // Config array; a write lands at the edge, so the datapath sees it on next use
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < N_COUNT; n++) r_cfg[n] <= '0;
    end else if (cfg_we) begin
      r_cfg[cfg_idx] <= cfg_data;
    end
  end

  // Merge this group's spike bits into the accumulator of the running fire
  always_comb begin
    w_spike_acc_next = r_spike_acc;
    for (int l = 0; l < LANES; l++)
      w_spike_acc_next[w_idx_flat[l*c_iw +: c_iw]] = w_lane_spike[l];
  end

  // Spike vector published atomically after the last group
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spike_acc    <= '0;
      r_spikes       <= '0;
      r_spikes_valid <= 1'b0;
    end else begin
      if (r_state == FIRE) r_spike_acc <= w_spike_acc_next;
      if (w_fire_done)     r_spikes    <= w_spike_acc_next;
      r_spikes_valid <= w_fire_done;
    end
  end

  // Tick bookkeeping and single-cycle status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_pending <= 1'b0;
      r_tick_overrun <= 1'b0;
      r_dropped      <= 1'b0;
    end else begin
      r_tick_pending <= w_fire_done ? 1'b0 : (r_tick_pending || tick);
      r_tick_overrun <= tick && (r_tick_pending || (r_state == FIRE));
      r_dropped      <= pkt_valid && w_fifo_full && !w_pop;
    end
  end

  assign sram_addr      = r_addr;
  assign spikes         = r_spikes;
  assign spikes_valid   = r_spikes_valid;
  assign tick_overrun   = r_tick_overrun;
  assign dropped_packet = r_dropped;
  assign busy           = (r_state != IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_neuron_array_controller.sv
`default_nettype none
// ============================================================================
// Module    : tb_neuron_array_controller
// Purpose   : Self-checking bench; two instances (reset modes 1 and 0) share
//             all inputs, expected spike vectors come from a reference model
// Revision  : 1.0  initial release
// ============================================================================
module tb_neuron_array_controller;
  import neuron_array_controller_pkg::*;

  localparam int N   = 256;
  localparam int AW  = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, pkt_valid, tick, cfg_we;
  logic [AW-1:0]     pkt_axon;
  logic [N-1:0]      sram_rd;
  logic [7:0]        cfg_idx;
  neuron_cfg_t       cfg_data;
  logic              r_resp, late_resp, sram_stall;
  wire               sram_resp = r_resp | late_resp;

  logic              drop1, ovr1, req1, sv1, busy1;
  logic              drop0, ovr0, req0, sv0, busy0;
  logic [AW-1:0]     addr1, addr0;
  logic [N-1:0]      spikes1, spikes0;

  neuron_array_controller #(.RESET_MODE(1)) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_axon(pkt_axon),
    .dropped_packet(drop1), .tick(tick), .tick_overrun(ovr1), .sram_req(req1),
    .sram_addr(addr1), .sram_resp(sram_resp), .sram_rd(sram_rd), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .spikes(spikes1), .spikes_valid(sv1),
    .busy(busy1));

  neuron_array_controller #(.RESET_MODE(0)) dut_m0 (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_axon(pkt_axon),
    .dropped_packet(drop0), .tick(tick), .tick_overrun(ovr0), .sram_req(req0),
    .sram_addr(addr0), .sram_resp(sram_resp), .sram_rd(sram_rd), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .spikes(spikes0), .spikes_valid(sv0),
    .busy(busy0));

  int errors = 0;
  int checks = 0;
  int n_drop = 0, n_ovr = 0, n_sv = 0;

  // Reference model state (m_v1: subtractive reset, m_v0: reset to zero)
  int m_v1[N], m_v0[N], m_w[N], m_leak[N], m_vth[N];
  logic [N-1:0] q1[$], q0[$];

  function automatic int sat(int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // Synapse contents: axon 5 feeds neuron 3, every other axon feeds its own index
  function automatic logic [N-1:0] row_of(int a);
    logic [N-1:0] r;
    r = '0;
    if (a == 5) r[3] = 1'b1;
    else        r[a] = 1'b1;
    return r;
  endfunction

  function automatic void apply_pkt(int a);
    logic [N-1:0] r;
    r = row_of(a);
    for (int n = 0; n < N; n++) begin
      if (r[n]) begin
        m_v1[n] = sat(m_v1[n] + m_w[n]);
        m_v0[n] = sat(m_v0[n] + m_w[n]);
      end
    end
  endfunction

  function automatic void model_tick();
    logic [N-1:0] e1, e0;
    int vl;
    for (int n = 0; n < N; n++) begin
      vl = sat(m_v1[n] - m_leak[n]);
      if (vl >= m_vth[n]) begin e1[n] = 1'b1; m_v1[n] = sat(vl - m_vth[n]); end
      else                begin e1[n] = 1'b0; m_v1[n] = vl; end
      vl = sat(m_v0[n] - m_leak[n]);
      if (vl >= m_vth[n]) begin e0[n] = 1'b1; m_v0[n] = 0; end
      else                begin e0[n] = 1'b0; m_v0[n] = vl; end
    end
    q1.push_back(e1);
    q0.push_back(e0);
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < N; n++) begin
      m_v1[n] = 0; m_v0[n] = 0; m_w[n] = 0; m_leak[n] = 0; m_vth[n] = 0;
    end
    q1.delete();
    q0.delete();
  endfunction

  // Synapse SRAM: answers LAT cycles into a request unless stalled
  initial begin
    int cnt;
    cnt = 0; r_resp = 1'b0; sram_rd = '0;
    forever begin
      @(posedge clk); #1;
      if (!sram_stall) begin
        if (r_resp) r_resp = 1'b0;
        else if (req1) begin
          cnt++;
          if (cnt >= LAT) begin
            r_resp = 1'b1; sram_rd = row_of(int'(addr1)); cnt = 0;
          end
        end else cnt = 0;
      end
    end
  end

  // Pulse counters
  initial begin
    forever begin
      @(negedge clk);
      if (drop1) n_drop++;
      if (ovr1)  n_ovr++;
      if (sv1)   n_sv++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic write_cfg(int n, int w, int lk, int vt);
    cfg_we = 1'b1; cfg_idx = 8'(n);
    cfg_data.weight = 8'(w); cfg_data.leak = 8'(lk); cfg_data.vthresh = 8'(vt);
    cycle();
    cfg_we = 1'b0;
    m_w[n] = w; m_leak[n] = lk; m_vth[n] = vt;
  endtask

  // Back-to-back packets; the first n_accept are expected to be queued
  task automatic send_burst(int first, int count, int n_accept);
    for (int i = 0; i < count; i++) begin
      pkt_valid = 1'b1; pkt_axon = AW'(first + i);
      cycle();
      if (i < n_accept) apply_pkt(first + i);
    end
    pkt_valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cycle(); tick = 1'b0;
    model_tick();
  endtask

  task automatic wait_idle(string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (!busy1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_idle: busy still 1 after 3000 cycles, want 0", name); end
  endtask

  task automatic wait_state(string name, ctrl_state_e st);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (dut.r_state == st) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_state: state %0d never reached", name, st); end
  endtask

  task automatic wait_spikes(string name);
    bit got;
    logic [N-1:0] e1, e0;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (sv1) got = 1'b1;
    end
    checks++;
    if (!got || q1.size() == 0) begin
      errors++;
      $display("FAIL %s_valid: spikes_valid seen=%0d, queued expectations=%0d", name, got, q1.size());
      q1.delete(); q0.delete();
      return;
    end
    e1 = q1.pop_front();
    e0 = q0.pop_front();
    checks++;
    if (spikes1 !== e1) begin
      errors++; $display("FAIL %s_spikes_m1: got %h want %h", name, spikes1, e1);
    end
    checks++;
    if (sv0 !== 1'b1 || spikes0 !== e0) begin
      errors++; $display("FAIL %s_spikes_m0: valid=%0b got %h want %h", name, sv0, spikes0, e0);
    end
  endtask

  task automatic check_v(string name, int n);
    checks++;
    if (int'(dut.r_v[n]) !== m_v1[n] || int'(dut_m0.r_v[n]) !== m_v0[n]) begin
      errors++;
      $display("FAIL %s_v%0d: got %0d/%0d want %0d/%0d", name, n,
               int'(dut.r_v[n]), int'(dut_m0.r_v[n]), m_v1[n], m_v0[n]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; pkt_valid = 1'b0; pkt_axon = '0; tick = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_data = '0; late_resp = 1'b0; sram_stall = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({drop1, ovr1, req1, addr1, spikes1, sv1, busy1} !== '0) begin
      errors++; $display("FAIL reset_outputs_m1: got req=%0b busy=%0b spikes=%h want all 0", req1, busy1, spikes1);
    end
    checks++;
    if ({drop0, ovr0, req0, addr0, spikes0, sv0, busy0} !== '0) begin
      errors++; $display("FAIL reset_outputs_m0: got req=%0b busy=%0b spikes=%h want all 0", req0, busy0, spikes0);
    end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    write_cfg(3, 2, 1, 3);
    send_burst(5, 1, 1);
    send_burst(5, 1, 1);
    wait_idle("basic");
    checks++;
    if (int'(dut.r_v[3]) !== 4) begin errors++; $display("FAIL basic_v3_integrated: got %0d want 4", int'(dut.r_v[3])); end
    do_tick();
    wait_spikes("basic_t1");
    checks++;
    if (spikes1[3] !== 1'b1) begin errors++; $display("FAIL basic_spike3: got %0b want 1", spikes1[3]); end
    check_v("basic", 3);
    do_tick();
    wait_spikes("basic_t2");
  endtask

  task automatic test_fifo_drop();
    int d0;
    for (int n = 16; n <= 26; n++) write_cfg(n, 1, 0, 127);
    sram_stall = 1'b1;
    d0 = n_drop;
    send_burst(16, 1, 1);
    repeat (3) cycle();
    send_burst(17, 10, 8);
    repeat (3) cycle();
    checks++;
    if (n_drop - d0 !== 2) begin errors++; $display("FAIL fifo_drop_count: got %0d want 2", n_drop - d0); end
    sram_stall = 1'b0;
    wait_idle("fifo");
    for (int n = 16; n <= 26; n++) check_v("fifo", n);
    checks++;
    if (int'(dut.r_v[24]) !== 1 || int'(dut.r_v[25]) !== 0) begin
      errors++; $display("FAIL fifo_last_kept_first_dropped: got %0d/%0d want 1/0", int'(dut.r_v[24]), int'(dut.r_v[25]));
    end
    do_tick();
    wait_spikes("fifo");
  endtask

  task automatic test_saturation();
    write_cfg(0, 127, 0, 127);
    write_cfg(1, -128, 0, 127);
    write_cfg(2, -128, 127, 127);
    send_burst(0, 1, 1); send_burst(0, 1, 1); send_burst(0, 1, 1);
    send_burst(1, 1, 1); send_burst(1, 1, 1);
    send_burst(2, 1, 1);
    wait_idle("sat");
    checks++;
    if (int'(dut.r_v[0]) !== 127 || int'(dut.r_v[1]) !== -128) begin
      errors++; $display("FAIL sat_clamp: got %0d/%0d want 127/-128", int'(dut.r_v[0]), int'(dut.r_v[1]));
    end
    for (int n = 0; n <= 2; n++) check_v("sat", n);
    do_tick();
    wait_spikes("sat");
    for (int n = 0; n <= 2; n++) check_v("sat_fire", n);
  endtask

  task automatic test_reset_mode();
    write_cfg(7, 7, 0, 3);
    send_burst(7, 1, 1);
    wait_idle("mode");
    do_tick();
    wait_spikes("mode_t1");
    checks++;
    if (int'(dut.r_v[7]) !== 4 || int'(dut_m0.r_v[7]) !== 0) begin
      errors++; $display("FAIL mode_after_fire1: got %0d/%0d want 4/0", int'(dut.r_v[7]), int'(dut_m0.r_v[7]));
    end
    do_tick();
    wait_spikes("mode_t2");
    check_v("mode", 7);
    do_tick();
    wait_spikes("mode_t3");
    checks++;
    if (spikes1[7] !== 1'b0 || int'(dut.r_v[7]) !== 1) begin
      errors++; $display("FAIL mode_no_spike: got spike=%0b v=%0d want 0 and 1", spikes1[7], int'(dut.r_v[7]));
    end
  endtask

  task automatic test_tick_priority();
    int o0, s0;
    for (int n = 60; n <= 63; n++) write_cfg(n, 5, 1, 4);
    sram_stall = 1'b1;
    send_burst(60, 1, 1);
    repeat (3) cycle();
    send_burst(61, 3, 3);
    o0 = n_ovr; s0 = n_sv;
    do_tick();
    sram_stall = 1'b0;
    wait_state("prio", FIRE);
    tick = 1'b1; cycle(); tick = 1'b0;
    wait_spikes("prio");
    repeat (300) cycle();
    checks++;
    if (n_ovr - o0 !== 1) begin errors++; $display("FAIL prio_overrun: got %0d pulses want 1", n_ovr - o0); end
    checks++;
    if (n_sv - s0 !== 1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL prio_single_fire: got %0d fires busy=%0b want 1 fire busy=0", n_sv - s0, busy1);
    end
    for (int n = 60; n <= 63; n++) check_v("prio", n);
  endtask

  task automatic test_reset_in_wait();
    bit bad;
    sram_stall = 1'b1;
    send_burst(5, 1, 1);
    wait_state("rstwait", WAIT);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (req1 !== 1'b0 || busy1 !== 1'b0 || req0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL rstwait_async: got req=%0b busy=%0b want 0 0", req1, busy1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    cycle();
    late_resp = 1'b1; cycle(); late_resp = 1'b0;
    repeat (5) cycle();
    checks++;
    if (req1 !== 1'b0 || busy1 !== 1'b0 || spikes1 !== '0) begin
      errors++; $display("FAIL rstwait_late_resp: got req=%0b busy=%0b want 0 0", req1, busy1);
    end
    bad = 1'b0;
    for (int n = 0; n < N; n++)
      if (dut.r_v[n] !== '0 || dut_m0.r_v[n] !== '0) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL rstwait_potentials: got nonzero potential want all 0"); end
    sram_stall = 1'b0;
    do_tick();
    wait_spikes("rstwait");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_drop();
    test_saturation();
    test_reset_mode();
    test_tick_priority();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
